// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch/decode types and constants.
package fetch_pkg;
    localparam int INSTR_W = 30;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int XLEN_DEF = 32;

    function automatic int addr_w(input int xlen);
        return xlen - 5;
    endfunction

    typedef struct packed {
        logic [addr_w(XLEN_DEF)-1:0] addr;
        logic [INSTR_W-1:0]          instr;
    } fetch_entry_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: owns first/last/count, clamps push/pop requests and decides push acceptance.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int PUSH_W = 2,
    parameter int POP_W = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int PCW = $clog2(PUSH_W + 1),
    localparam int OCW = $clog2(POP_W + 1)
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           flush,
    input  logic [PCW-1:0] push_count,
    input  logic [OCW-1:0] pop_count,
    output logic [PW-1:0]  first,
    output logic [PW-1:0]  last,
    output logic [CW-1:0]  count,
    output logic [CW-1:0]  free_slots,
    output logic [CW-1:0]  push_n,
    output logic           push_en,
    output logic           queue_empty,
    output logic           queue_full,
    output logic           push_drop
);
    logic [CW-1:0] pop_n;
    logic [CW-1:0] popped;
    logic          accept;

    // acceptance is judged against occupancy before this cycle's pop
    always_comb begin
        push_n = (push_count > PCW'(PUSH_W)) ? CW'(PUSH_W) : CW'(push_count);
        pop_n = (pop_count > OCW'(POP_W)) ? CW'(POP_W) : CW'(pop_count);
        popped = (pop_n < count) ? pop_n : count;
        free_slots = CW'(DEPTH) - count;
        accept = push_n <= free_slots;
        push_en = accept && (push_n != '0) && !flush;
        queue_empty = count == '0;
        queue_full = free_slots < CW'(PUSH_W);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            first <= '0;
            last <= '0;
            count <= '0;
            push_drop <= 1'b0;
        end else if (flush) begin
            first <= '0;
            last <= '0;
            count <= '0;
            push_drop <= 1'b0;
        end else begin
            first <= first + popped[PW-1:0];
            if (push_en)
                last <= last + push_n[PW-1:0];
            count <= count - popped + (push_en ? push_n : '0);
            push_drop <= !accept && (push_n != '0);
        end
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: multi-port circular instruction queue between fetch and dual-issue decode.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DEPTH = 8,
    parameter int PUSH_W = 2,
    parameter int POP_W = 2,
    parameter logic [31:0] NOP = NOP_WORD,
    localparam int AW = addr_w(XLEN),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int PCW = $clog2(PUSH_W + 1),
    localparam int OCW = $clog2(POP_W + 1)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [PCW-1:0]            pushCount,
    input  logic [PUSH_W*INSTR_W-1:0] instrIn,
    input  logic [PUSH_W*AW-1:0]      iAddrIn,
    input  logic [OCW-1:0]            popCount,
    output logic [POP_W*INSTR_W-1:0]  instrOut,
    output logic [POP_W*AW-1:0]       iAddrOut,
    output logic [POP_W-1:0]          outValid,
    output logic [CW-1:0]             count,
    output logic [CW-1:0]             freeSlots,
    output logic                      queueEmpty,
    output logic                      queueFull,
    output logic                      pushDrop
);
    typedef struct packed {
        logic [AW-1:0]      addr;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] first;
    logic [PW-1:0] last;
    logic [CW-1:0] push_n;
    logic          push_en;
    logic [PW-1:0] wr_idx [PUSH_W];

    fifo_ptr_ctrl #(
        .DEPTH(DEPTH),
        .PUSH_W(PUSH_W),
        .POP_W(POP_W)
    ) u_ctrl (
        .clock(clock),
        .resetn(resetn),
        .flush(flush),
        .push_count(pushCount),
        .pop_count(popCount),
        .first(first),
        .last(last),
        .count(count),
        .free_slots(freeSlots),
        .push_n(push_n),
        .push_en(push_en),
        .queue_empty(queueEmpty),
        .queue_full(queueFull),
        .push_drop(pushDrop)
    );

    always_comb begin
        for (int i = 0; i < PUSH_W; i++)
            wr_idx[i] = last + PW'(i);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else if (push_en) begin
            for (int i = 0; i < PUSH_W; i++)
                if (CW'(i) < push_n)
                    mem[wr_idx[i]] <= entry_t'({iAddrIn[i*AW +: AW], instrIn[i*INSTR_W +: INSTR_W]});
        end
    end

    // lanes beyond occupancy present a NOP so decode never sees stale data
    for (genvar j = 0; j < POP_W; j++) begin : g_lane
        logic [PW-1:0] rd_idx;
        assign rd_idx = first + PW'(j);
        assign outValid[j] = count > CW'(j);
        assign instrOut[j*INSTR_W +: INSTR_W] = outValid[j] ? mem[rd_idx].instr : NOP[31:2];
        assign iAddrOut[j*AW +: AW] = outValid[j] ? mem[rd_idx].addr : '0;
    end

    a_push_legal: assert property (@(posedge clock) disable iff (!resetn) pushCount <= PCW'(PUSH_W));
    a_pop_legal: assert property (@(posedge clock) disable iff (!resetn) popCount <= OCW'(POP_W));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench for instr_fetch_queue with a queue-based reference model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  pushCount = '0;
    logic [59:0] instrIn = '0;
    logic [53:0] iAddrIn = '0;
    logic [1:0]  popCount = '0;
    logic [59:0] instrOut;
    logic [53:0] iAddrOut;
    logic [1:0]  outValid;
    logic [3:0]  count;
    logic [3:0]  freeSlots;
    logic        queueEmpty;
    logic        queueFull;
    logic        pushDrop;

    instr_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .PUSH_W(2), .POP_W(2)) dut (
        .clock(clock),
        .resetn(resetn),
        .flush(flush),
        .pushCount(pushCount),
        .instrIn(instrIn),
        .iAddrIn(iAddrIn),
        .popCount(popCount),
        .instrOut(instrOut),
        .iAddrOut(iAddrOut),
        .outValid(outValid),
        .count(count),
        .freeSlots(freeSlots),
        .queueEmpty(queueEmpty),
        .queueFull(queueFull),
        .pushDrop(pushDrop)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [26:0] a;
        logic [29:0] i;
    } ent_t;

    typedef struct {
        int          cnt;
        bit          drop;
        logic [1:0]  vld;
        logic [59:0] ins;
        logic [53:0] adr;
    } exp_t;

    ent_t        mq[$];
    bit          m_drop = 1'b0;
    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] nop32 = 32'h0000_0013;
    logic [29:0] nopi;

    initial nopi = nop32[31:2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference: a plain queue following the push/pop/flush rules
    function automatic void model_step(input int pc, input logic [29:0] i0, input logic [29:0] i1,
                                       input logic [26:0] a0, input logic [26:0] a1, input int oc, input bit fl);
        int sz;
        int popped;
        bit acc;
        if (fl) begin
            mq.delete();
            m_drop = 1'b0;
        end else begin
            sz = mq.size();
            popped = (oc < sz) ? oc : sz;
            acc = pc <= DEPTH - sz;
            m_drop = (pc > 0) && !acc;
            repeat (popped) void'(mq.pop_front());
            if (acc && pc > 0) mq.push_back({a0, i0});
            if (acc && pc > 1) mq.push_back({a1, i1});
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.cnt = mq.size();
        e.drop = m_drop;
        e.vld = '0;
        e.ins = {nopi, nopi};
        e.adr = '0;
        for (int j = 0; j < 2; j++)
            if (j < mq.size()) begin
                e.vld[j] = 1'b1;
                e.ins[j*30 +: 30] = mq[j].i;
                e.adr[j*27 +: 27] = mq[j].a;
            end
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input int pc, input logic [29:0] i0, input logic [29:0] i1,
                       input logic [26:0] a0, input logic [26:0] a1, input int oc, input bit fl);
        pushCount = 2'(pc);
        instrIn = {i1, i0};
        iAddrIn = {a1, a0};
        popCount = 2'(oc);
        flush = fl;
        @(posedge clock);
        #1;
        model_step(pc, i0, i1, a0, a1, oc, fl);
        push_exp();
        pushCount = '0;
        popCount = '0;
        flush = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 64'(count), 64'(e.cnt));
                chk("freeSlots", 64'(freeSlots), 64'(DEPTH - e.cnt));
                chk("queueEmpty", 64'(queueEmpty), 64'(e.cnt == 0));
                chk("queueFull", 64'(queueFull), 64'((DEPTH - e.cnt) < 2));
                chk("pushDrop", 64'(pushDrop), 64'(e.drop));
                chk("outValid", 64'(outValid), 64'(e.vld));
                chk("instrOut", 64'(instrOut), 64'(e.ins));
                chk("iAddrOut", 64'(iAddrOut), 64'(e.adr));
            end
        end
    end

    initial begin : stim
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        chk("rst_count", 64'(count), 0);
        chk("rst_free", 64'(freeSlots), 8);
        chk("rst_empty", 64'(queueEmpty), 1);
        chk("rst_valid", 64'(outValid), 0);
        chk("rst_instr", 64'(instrOut), 64'({nopi, nopi}));
        chk("rst_addr", 64'(iAddrOut), 0);
        chk("rst_drop", 64'(pushDrop), 0);

        cyc(2, 30'h1, 30'h2, 27'h10, 27'h11, 0, 0);
        chk("t1_valid", 64'(outValid), 3);
        chk("t1_lane0", 64'(instrOut[29:0]), 1);
        chk("t1_lane1", 64'(instrOut[59:30]), 2);
        chk("t1_free", 64'(freeSlots), 6);
        cyc(0, 0, 0, 0, 0, 2, 0);

        cyc(1, 30'hA, 30'h0, 27'h20, 27'h0, 0, 0);
        chk("t2_valid", 64'(outValid), 1);
        chk("t2_lane1", 64'(instrOut[59:30]), 64'(nopi));
        cyc(0, 0, 0, 0, 0, 2, 0);
        chk("t2_count", 64'(count), 0);

        for (int k = 0; k < 3; k++) cyc(2, 30'(k*2), 30'(k*2+1), 27'(k), 27'(k), 0, 0);
        cyc(1, 30'h6, 0, 27'h6, 0, 0, 0);
        cyc(2, 30'h7, 30'h8, 27'h7, 27'h8, 0, 0);
        chk("t3_count", 64'(count), 7);
        chk("t3_drop", 64'(pushDrop), 1);
        chk("t3_full", 64'(queueFull), 1);
        cyc(1, 30'h9, 0, 27'h9, 0, 0, 0);
        chk("t3_count8", 64'(count), 8);
        chk("t3_drop_clr", 64'(pushDrop), 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 2, 0);

        cyc(2, 30'd0, 30'd1, 27'h100, 27'h101, 0, 0);
        cyc(2, 30'd2, 30'd3, 27'h102, 27'h103, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("ss_head", 64'(instrOut[29:0]), 64'(2*k));
            chk("ss_count", 64'(count), 4);
            cyc(2, 30'(4+2*k), 30'(5+2*k), 27'(260+2*k), 27'(261+2*k), 2, 0);
        end
        chk("ss_head_end", 64'(instrOut[29:0]), 20);
        repeat (2) cyc(0, 0, 0, 0, 0, 2, 0);

        cyc(2, 30'h50, 30'h51, 27'h50, 27'h51, 0, 0);
        cyc(2, 30'h52, 30'h53, 27'h52, 27'h53, 0, 0);
        cyc(1, 30'h54, 0, 27'h54, 0, 0, 0);
        chk("fl_pre", 64'(count), 5);
        cyc(2, 30'h55, 30'h56, 27'h55, 27'h56, 2, 1);
        chk("fl_count", 64'(count), 0);
        chk("fl_valid", 64'(outValid), 0);
        chk("fl_drop", 64'(pushDrop), 0);
        cyc(1, 30'h77, 0, 27'h77, 0, 0, 0);
        chk("fl_lane0", 64'(instrOut[29:0]), 64'h77);

        cyc(2, 30'h60, 30'h61, 27'h60, 27'h61, 0, 0);
        cyc(2, 30'h62, 30'h63, 27'h62, 27'h63, 0, 0);
        cyc(1, 30'h64, 0, 27'h64, 0, 0, 0);
        chk("ar_pre", 64'(count), 6);
        @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar_count", 64'(count), 0);
        chk("ar_empty", 64'(queueEmpty), 1);
        chk("ar_valid", 64'(outValid), 0);
        mq.delete();
        m_drop = 1'b0;
        #1;
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 2), 30'($urandom), 30'($urandom), 27'($urandom), 27'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 19) == 0);

        repeat (3) @(negedge clock);
        #1;
        chk("drain", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
